rx_sample_scheduler: RTL and testbench

//  Sequences the NR shared-clock receiver outputs (I/Q) into a single ordered stream for the

---
 rtl/rx_sched_pkg.sv | 26 ++
 rtl/rx_capture_slot.sv | 44 ++++
 rtl/rx_sample_scheduler.sv | 171 +++++++++++++++++
 tb/tb_rx_sample_scheduler.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_sched_pkg.sv
// Shared types and helpers for the receiver sample scheduler.
// Holds the sequencer state enum, the channel-index and overrun-counter widths,
// and the helper that turns the raw active-channel setting into a usable count.
package rx_sched_pkg;

  // Channel-index width; covers up to 15 receiver channels.
  localparam int CHW       = 4;
  // Width of the saturating overrun counter.
  localparam int OVR_CNT_W = 8;

  // Sequencer states: WAIT for the current channel's sample, EMIT it downstream.
  typedef enum logic {
    WAIT = 1'b0,
    EMIT = 1'b1
  } sched_state_t;

  // Convert the configured receiver count into a legal one.
  // Zero means one channel; anything above the instantiated count is clipped.
  function automatic logic [CHW-1:0] clamp_nrx(input logic [CHW-1:0] cfg,
                                               input int           nr);
    if (cfg == '0) return CHW'(1);
    if (int'(cfg) > nr) return CHW'(nr);
    return cfg;
  endfunction

endpackage

// File: rtl/rx_capture_slot.sv
// One receiver channel's single-sample buffer.
// Captures the {I,Q} word on its strobe, flags it pending until the sequencer
// takes it, and reports when a still-pending sample gets overwritten.
module rx_capture_slot #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         strobe,
  input  logic [W-1:0] sample,
  input  logic         consume,
  output logic [W-1:0] cap,
  output logic         pend,
  output logic         ovr
);

  // A new sample landing on an unconsumed one is an overrun; the newest wins.
  assign ovr = strobe && en && pend && !consume;

  // Pending flag: set by a capture, cleared by the sequencer taking the word.
  // A capture in the same cycle as a consume keeps the flag set for the new word.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    if (rst) begin
      pend <= 1'b0;
    end else if (strobe && en) begin
      pend <= 1'b1;
    end else if (consume) begin
      pend <= 1'b0;
    end
  end

  // Sample storage. The consume path reads the value from before this edge.
  always_ff @(posedge clk) begin
    // NOTE: the data register has no reset; it is only ever read when pend is
    // set, and pend is reset, so clearing the payload would buy nothing.
    if (strobe && en) begin
      cap <= sample;
    end
  end

endmodule

// File: rtl/rx_sample_scheduler.sv
// Receiver sample scheduler: walks channels 0..nrx-1 in strict order and
// forwards one {I,Q} word per channel per frame to the packet builder,
// using a valid/ready handshake on the output side.
// Optional build macro RX_SCHED_OVERRUN_CNT_EN enables the saturating
// overrun counter; without it overrun_cnt reads zero and only the pulse exists.
module rx_sample_scheduler
  import rx_sched_pkg::*;
#(
  parameter int NR = 9,
  parameter int DW = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CHW-1:0]       cfg_nrx,
  input  logic [NR-1:0]        rx_valid,
  input  logic [NR*DW-1:0]     rx_i,
  input  logic [NR*DW-1:0]     rx_q,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*DW-1:0]      out_data,
  output logic [CHW-1:0]       out_chan,
  output logic                 out_last,
  output logic                 overrun,
  output logic [OVR_CNT_W-1:0] overrun_cnt
);

  sched_state_t   state;
  sched_state_t   state_nxt;
  logic [CHW-1:0] idx;
  logic [CHW-1:0] nrx_l;
  logic           cfg_load;   // one-shot: pick up cfg_nrx right after reset
  logic           load_word;  // WAIT -> EMIT: take cap[idx] into the output regs
  logic           advance;    // EMIT handshake completed: move to the next channel

  logic [NR-1:0]   chan_en;
  logic [NR-1:0]   consume;
  logic [NR-1:0]   pend;
  logic [NR-1:0]   ovr;
  logic [2*DW-1:0] cap [NR];

  logic            pend_sel;
  logic [2*DW-1:0] cap_sel;

  // Per-channel capture slots; channels at or above nrx_l ignore their strobes.
  for (genvar k = 0; k < NR; k++) begin : g_slot
    assign chan_en[k] = (CHW'(k) < nrx_l);
    assign consume[k] = load_word && (idx == CHW'(k));

    rx_capture_slot #(
      .W(2*DW)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .en     (chan_en[k]),
      .strobe (rx_valid[k]),
      .sample ({rx_i[k*DW +: DW], rx_q[k*DW +: DW]}),
      .consume(consume[k]),
      .cap    (cap[k]),
      .pend   (pend[k]),
      .ovr    (ovr[k])
    );
  end

  // Select the slot the sequencer is currently waiting on.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    pend_sel = 1'b0;
    cap_sel  = '0;
    for (int k = 0; k < NR; k++) begin
      if (idx == CHW'(k)) begin
        pend_sel = pend[k];
        cap_sel  = cap[k];
      end
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and control strobes. WAIT never skips a channel: it holds
  // until the channel at idx has a sample.
  always_comb begin
    state_nxt = state;
    load_word = 1'b0;
    advance   = 1'b0;
    unique case (state)
      WAIT: begin
        if (pend_sel) begin
          load_word = 1'b1;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          advance   = 1'b1;
          state_nxt = WAIT;
        end
      end
      default: state_nxt = WAIT;
    endcase
  end

  // Output word registers; held stable for the whole EMIT phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      out_last  <= 1'b0;
    end else if (load_word) begin
      out_valid <= 1'b1;
      out_data  <= cap_sel;
      out_chan  <= idx;
      out_last  <= (idx == nrx_l - CHW'(1));
    end else if (advance) begin
      out_valid <= 1'b0;
    end
  end

  // Channel index and frame length. The active count only changes at a
  // frame boundary so a frame in flight always completes with its own length.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      nrx_l    <= CHW'(1);
      cfg_load <= 1'b1;
    end else begin
      if (advance) begin
        idx <= out_last ? '0 : idx + CHW'(1);
      end
      if (cfg_load || (advance && out_last)) begin
        nrx_l <= clamp_nrx(cfg_nrx, NR);
      end
      cfg_load <= 1'b0;
    end
  end

  // Overrun pulse: any number of overwrites in one cycle gives a single pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else begin
      overrun <= |ovr;
    end
  end

`ifdef RX_SCHED_OVERRUN_CNT_EN
  logic [OVR_CNT_W-1:0] ovr_cnt;

  // Saturating overrun counter, one step per overrun cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_cnt <= '0;
    end else if ((|ovr) && (ovr_cnt != '1)) begin
      ovr_cnt <= ovr_cnt + OVR_CNT_W'(1);
    end
  end

  assign overrun_cnt = ovr_cnt;
`else
  assign overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_rx_sample_scheduler.sv
// Directed testbench for rx_sample_scheduler (NR=9, DW=24).
// A per-cycle vector table covers the basic frame and wait-for-channel cases;
// hand-written sequences cover backpressure/overrun, config changes, clamping
// and reset in the middle of a frame.
module tb_rx_sample_scheduler;
  import rx_sched_pkg::*;

  localparam int NR = 9;
  localparam int DW = 24;
`ifdef RX_SCHED_OVERRUN_CNT_EN
  localparam logic [7:0] EXP_OVR_CNT = 8'd1;
`else
  localparam logic [7:0] EXP_OVR_CNT = 8'd0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [CHW-1:0]   cfg_nrx;
  logic [NR-1:0]    rx_valid;
  logic [NR*DW-1:0] rx_i;
  logic [NR*DW-1:0] rx_q;
  logic             out_valid;
  logic             out_ready;
  logic [2*DW-1:0]  out_data;
  logic [CHW-1:0]   out_chan;
  logic             out_last;
  logic             overrun;
  logic [7:0]       overrun_cnt;

  int total = 0;
  int bad   = 0;

  rx_sample_scheduler #(.NR(NR), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_nrx    (cfg_nrx),
    .rx_valid   (rx_valid),
    .rx_i       (rx_i),
    .rx_q       (rx_q),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_chan   (out_chan),
    .out_last   (out_last),
    .overrun    (overrun),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0]  rv;
    logic           rdy;
    logic [CHW-1:0] cfg;
    logic [7:0]     gen;
    logic           exp_valid;
    logic [CHW-1:0] exp_chan;
    logic           exp_last;
    logic [7:0]     exp_gen;
  } vec_t;

  vec_t vecs[$];

  // Sample pattern: {I,Q} for channel k, generation g.
  function automatic logic [47:0] smp(input int k, input logic [7:0] g);
    return {g, 8'hA5, 8'(k), g ^ 8'hFF, 8'h5A, 8'(k)};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_samples(input logic [7:0] g);
    logic [47:0] s;
    for (int k = 0; k < NR; k++) begin
      s = smp(k, g);
      rx_i[k*DW +: DW] = s[47:24];
      rx_q[k*DW +: DW] = s[23:0];
    end
  endtask

  task automatic strobe(input logic [NR-1:0] rv, input logic [7:0] g);
    set_samples(g);
    rx_valid = rv;
    tick();
    rx_valid = '0;
  endtask

  task automatic do_reset(input logic [CHW-1:0] cfg);
    rst      = 1'b1;
    cfg_nrx  = cfg;
    rx_valid = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Wait (bounded) for a word, check it, and let the handshake consume it.
  task automatic expect_word(input string name, input logic [CHW-1:0] chan,
                             input logic last, input logic [7:0] g);
    logic [47:0] d;
    int n;
    d = smp(int'(chan), g);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check({name, "_word"}, 64'({out_chan, out_last, out_data}), 64'({chan, last, d}));
    tick();
  endtask

  task automatic expect_idle(input string name, input int cycles);
    logic quiet;
    quiet = 1'b1;
    for (int n = 0; n < cycles; n++) begin
      tick();
      if (out_valid) quiet = 1'b0;
    end
    check(name, 64'(quiet), 64'd1);
  endtask

  task automatic add_vec(input logic [NR-1:0] rv, input logic rdy, input logic [CHW-1:0] cfg,
                         input logic [7:0] gen, input logic ev, input logic [CHW-1:0] ec,
                         input logic el, input logic [7:0] eg);
    vec_t v;
    v.rv = rv; v.rdy = rdy; v.cfg = cfg; v.gen = gen;
    v.exp_valid = ev; v.exp_chan = ec; v.exp_last = el; v.exp_gen = eg;
    vecs.push_back(v);
  endtask

  initial begin
    logic [47:0] d;
    logic        stable;
    int          pulses;

    rst       = 1'b1;
    cfg_nrx   = 4'd3;
    rx_valid  = '0;
    rx_i      = '0;
    rx_q      = '0;
    out_ready = 1'b1;

    // Reset state, observed while reset is still held.
    tick();
    tick();
    check("reset_outputs", 64'({out_valid, out_chan, out_last, overrun, overrun_cnt, out_data}), 64'd0);
    rst = 1'b0;
    tick();

    // Test 1: nrx=3, all three strobed together, ready held high.
    add_vec(9'b000000111, 1, 3, 1, 0, 0, 0, 0);
    add_vec(9'b000000000, 1, 3, 1, 1, 0, 0, 1);
    add_vec(9'b000000000, 1, 3, 1, 0, 0, 0, 0);
    add_vec(9'b000000000, 1, 3, 1, 1, 1, 0, 1);
    add_vec(9'b000000000, 1, 3, 1, 0, 0, 0, 0);
    add_vec(9'b000000000, 1, 3, 1, 1, 2, 1, 1);
    add_vec(9'b000000000, 1, 2, 1, 0, 0, 0, 0);   // frame wraps, nrx becomes 2
    // Test 2: ch1 first, ch0 ten cycles later; nothing leaves until ch0 arrives.
    add_vec(9'b000000010, 1, 2, 2, 0, 0, 0, 0);
    for (int n = 0; n < 9; n++) add_vec(9'b0, 1, 2, 2, 0, 0, 0, 0);
    add_vec(9'b000000001, 1, 2, 3, 0, 0, 0, 0);
    add_vec(9'b000000000, 1, 2, 3, 1, 0, 0, 3);
    add_vec(9'b000000000, 1, 2, 3, 0, 0, 0, 0);
    add_vec(9'b000000000, 1, 2, 3, 1, 1, 1, 2);
    add_vec(9'b000000000, 1, 2, 3, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      rx_valid  = vecs[i].rv;
      out_ready = vecs[i].rdy;
      cfg_nrx   = vecs[i].cfg;
      set_samples(vecs[i].gen);
      tick();
      rx_valid = '0;
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        d = smp(int'(vecs[i].exp_chan), vecs[i].exp_gen);
        check($sformatf("vec%0d_word", i), 64'({out_chan, out_last, out_data}),
              64'({vecs[i].exp_chan, vecs[i].exp_last, d}));
      end
    end

    // Test 3: backpressure for 20 cycles while ch0 is strobed twice more.
    out_ready = 1'b0;
    strobe(9'b1, 8'd4);
    check("t3_lat_t1", 64'(out_valid), 64'd0);
    tick();
    d = smp(0, 8'd4);
    check("t3_lat_t2", 64'({out_valid, out_chan, out_data}), 64'({1'b1, 4'd0, d}));
    stable = 1'b1;
    pulses = 0;
    for (int n = 0; n < 20; n++) begin
      if (n == 3) begin
        set_samples(8'd5);
        rx_valid = 9'b1;
      end else if (n == 9) begin
        set_samples(8'd6);
        rx_valid = 9'b1;
      end else begin
        rx_valid = '0;
      end
      tick();
      rx_valid = '0;
      if (overrun) pulses++;
      if (!out_valid || out_data !== d || out_chan !== 4'd0) stable = 1'b0;
    end
    check("t3_stable", 64'(stable), 64'd1);
    check("t3_pulses", 64'(pulses), 64'd1);
    check("t3_ovr_cnt", 64'(overrun_cnt), 64'(EXP_OVR_CNT));
    out_ready = 1'b1;
    tick();
    check("t3_release", 64'(out_valid), 64'd0);
    strobe(9'b10, 8'd7);
    expect_word("t3_ch1", 4'd1, 1'b1, 8'd7);
    expect_word("t3_ch0_newest", 4'd0, 1'b0, 8'd6);
    expect_idle("t3_no_extra", 4);

    // Test 4: cfg 4 -> 2 mid-frame; the running frame still covers ch0..3.
    do_reset(4'd4);
    strobe(9'b1111, 8'd8);
    expect_word("t4_f1_ch0", 4'd0, 1'b0, 8'd8);
    cfg_nrx = 4'd2;
    expect_word("t4_f1_ch1", 4'd1, 1'b0, 8'd8);
    expect_word("t4_f1_ch2", 4'd2, 1'b0, 8'd8);
    expect_word("t4_f1_ch3", 4'd3, 1'b1, 8'd8);
    strobe(9'b1111, 8'd9);
    expect_word("t4_f2_ch0", 4'd0, 1'b0, 8'd9);
    expect_word("t4_f2_ch1", 4'd1, 1'b1, 8'd9);
    expect_idle("t4_f2_done", 6);

    // Test 5: cfg 0 behaves as 1 channel, cfg 15 as all 9.
    do_reset(4'd0);
    strobe(9'h1FF, 8'd10);
    expect_word("t5_n1_ch0", 4'd0, 1'b1, 8'd10);
    expect_idle("t5_n1_ignored", 5);
    cfg_nrx = 4'd15;
    strobe(9'b1, 8'd11);
    expect_word("t5_n1_again", 4'd0, 1'b1, 8'd11);
    strobe(9'h1FF, 8'd12);
    for (int k = 0; k < NR; k++) begin
      expect_word($sformatf("t5_n9_ch%0d", k), CHW'(k), (k == NR - 1), 8'd12);
    end
    expect_idle("t5_n9_done", 4);

    // Test 6: reset while EMIT is holding a word and other samples are pending.
    do_reset(4'd3);
    out_ready = 1'b0;
    strobe(9'b111, 8'd13);
    tick();
    check("t6_in_emit", 64'({out_valid, out_chan}), 64'({1'b1, 4'd0}));
    rst = 1'b1;
    tick();
    check("t6_reset_out", 64'({out_valid, out_chan, out_last, overrun, overrun_cnt, out_data}), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    expect_idle("t6_pend_cleared", 5);
    strobe(9'b1, 8'd14);
    expect_word("t6_idx0", 4'd0, 1'b0, 8'd14);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
